morse_matcher: RTL and testbench
================================

MORSE_MATCHER -- requirements
Module: morse_matcher

Interface
REQ-001 Parameter SYMBOLS, default 5, number of 2-bit Morse symbols per code word (range 1..16).
REQ-002 Parameter MAX_TRIES, default 3, wrong guesses allowed before the round is lost (range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 50000000, idle cycles allowed per symbol (used only with MORSE_TIMEOUT_EN).
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  system clock, all state on rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle pulse that begins a round and latches secret.
REQ-008 secret  input  2*SYMBOLS  player-1 code word, symbol 0 in the MSB pair.
REQ-009 ld_dot  input  1  single-cycle pulse, decoded dot from player 2.
REQ-010 ld_line  input  1  single-cycle pulse, decoded line from player 2.
REQ-011 guess  output  2*SYMBOLS  player-2 symbols accepted so far, newest in the LSB pair.
REQ-012 result  output  2  per-symbol verdict: 00 NEUTRAL, 01 CORRECT, 10 INCORRECT.
REQ-013 tries_left  output  $clog2(MAX_TRIES+1)  remaining wrong guesses.
REQ-014 busy, complete, failed  output  1 each  round active, round won, round lost.

Function
REQ-015 States SHALL be IDLE, LOAD, MATCH, WIN and LOSE; the encoding SHALL come from the package.
REQ-016 Symbol encoding SHALL be 00 none, 01 dot, 11 line; 10 in secret SHALL be treated as none.
REQ-017 start in any state SHALL enter LOAD on the next edge; start has priority over all other inputs.
REQ-018 LOAD SHALL latch secret into a working copy, clear guess and the symbol position, set tries_left=MAX_TRIES, and go to MATCH after one cycle.
REQ-019 In MATCH, when position equals SYMBOLS, the block SHALL go to WIN on the next edge.
REQ-020 In MATCH, a "none" symbol at the current position SHALL be skipped in one cycle with result=CORRECT, with no input required.
REQ-021 In MATCH, a dot or line pulse matching the current symbol SHALL advance the position, shift the symbol into guess, and set result=CORRECT.
REQ-022 In MATCH, a dot or line pulse that mismatches SHALL set result=INCORRECT, clear guess, rewind the position to 0, and decrement tries_left.
REQ-023 When a mismatch drops tries_left from 1 to 0, the block SHALL go to LOSE instead of continuing in MATCH.
REQ-024 If ld_dot and ld_line arrive together, ld_dot SHALL win and ld_line SHALL be ignored.
REQ-025 result SHALL be registered, valid exactly one cycle after the causing edge, and NEUTRAL in every other cycle.
REQ-026 Pulses outside MATCH SHALL be ignored.
REQ-027 busy=1 in LOAD and MATCH; complete=1 only in WIN; failed=1 only in LOSE; all are registered and glitch-free.
REQ-028 WIN and LOSE SHALL hold, with guess frozen, until start or reset.

Reset
REQ-029 resetn low SHALL asynchronously force IDLE, guess=0, result=NEUTRAL, tries_left=0, and busy=complete=failed=0.
REQ-030 Reset mid-round SHALL discard the round; after release, the block stays in IDLE until start.

Configuration
REQ-031 With MORSE_TIMEOUT_EN defined, TIMEOUT_CYCLES consecutive MATCH cycles without a pulse or skip SHALL count as one mismatch under REQ-022 and REQ-023, and the timer SHALL restart on every pulse, skip or LOAD.
REQ-032 Without MORSE_TIMEOUT_EN, no timer logic SHALL exist and MATCH waits indefinitely.

Structure
REQ-033 Package morse_pkg SHALL hold the symbol constants (NONE, DOT, LINE), the result constants (NEUTRAL, CORRECT, INCORRECT) and the state type.
REQ-034 The timeout counter SHALL be a sub-module morse_idle_timer, instantiated only under MORSE_TIMEOUT_EN.
REQ-035 ld_dot and ld_line SHALL be driven by the existing morse_decoder outside this block.

Verification (SYMBOLS=5, MAX_TRIES=3)
REQ-036 Win: secret=10'b0111010000, start, then dot, line, dot -> result CORRECT x3, two skip CORRECTs, complete=1, guess=10'b0000011101, tries_left=3.
REQ-037 Mismatch: same secret, start, then line -> result=INCORRECT, guess=0, tries_left=2; then dot, line, dot -> complete=1.
REQ-038 Lose: three wrong pulses -> tries_left 3,2,1,0; failed=1; busy=0; further pulses are ignored.
REQ-039 Simultaneous: ld_dot and ld_line together against symbol DOT -> result=CORRECT.
REQ-040 Reset mid-round: resetn low after one correct symbol -> all outputs return to reset values asynchronously; after release a new start is required.
REQ-041 With MORSE_TIMEOUT_EN and TIMEOUT_CYCLES=10: start, then no input for 10 MATCH cycles -> result=INCORRECT, tries_left=2.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared symbol, verdict and state definitions for the Morse code matching game.
package morse_pkg;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] DOT  = 2'b01;
    localparam logic [1:0] LINE = 2'b11;

    localparam logic [1:0] NEUTRAL   = 2'b00;
    localparam logic [1:0] CORRECT   = 2'b01;
    localparam logic [1:0] INCORRECT = 2'b10;

    typedef enum logic [2:0] {IDLE, LOAD, MATCH, WIN, LOSE} state_t;

    // The unused code 10 in a secret behaves exactly like an empty slot.
    function automatic logic is_none(input logic [1:0] s);
        return (s == NONE) || (s == 2'b10);
    endfunction

endpackage

// File: rtl/morse_idle_timer.sv
// Per-symbol idle watchdog for morse_matcher; only present when MORSE_TIMEOUT_EN is defined.
`ifdef MORSE_TIMEOUT_EN
module morse_idle_timer #(
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (!run || expired) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/morse_matcher.sv
// Two-player Morse game: player 2 must key in player 1's secret within MAX_TRIES mistakes.
// Define MORSE_TIMEOUT_EN to count TIMEOUT_CYCLES idle cycles on a symbol as a wrong guess.
module morse_matcher
    import morse_pkg::*;
#(
    parameter int SYMBOLS        = 5,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [2*SYMBOLS-1:0]           secret,
    input  logic                           ld_dot,
    input  logic                           ld_line,
    output logic [2*SYMBOLS-1:0]           guess,
    output logic [1:0]                     result,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic                           busy,
    output logic                           complete,
    output logic                           failed
);

    localparam int SW = 2 * SYMBOLS;
    localparam int PW = $clog2(SYMBOLS + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);

    if (SYMBOLS < 1 || SYMBOLS > 16 || MAX_TRIES < 1 || MAX_TRIES > 15 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("morse_matcher: parameter out of range");
    end

    state_t          state;
    logic [SW-1:0]   secret_q;
    logic [SW-1:0]   sec_shift;
    logic [PW-1:0]   pos;
    logic [1:0]      cur_sym;
    logic [1:0]      pulse_sym;
    logic            pulse;
    logic            at_end;
    logic            skip;
    logic            waiting;
    logic            hit;
    logic            miss;
    logic            timed_out;

    always_comb begin
        sec_shift = secret_q << {pos, 1'b0};
        cur_sym   = sec_shift[SW-1 -: 2];
        at_end    = (pos == PW'(SYMBOLS));
        skip      = (state == MATCH) && !at_end && is_none(cur_sym);
        waiting   = (state == MATCH) && !at_end && !is_none(cur_sym);
        pulse     = ld_dot || ld_line;
        pulse_sym = ld_dot ? DOT : LINE;
        hit       = waiting && pulse && (pulse_sym == cur_sym);
        miss      = waiting && ((pulse && !hit) || timed_out);
    end

`ifdef MORSE_TIMEOUT_EN
    morse_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clock   (clock),
        .resetn  (resetn),
        .run     (waiting && !pulse),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    // Working copy of the secret; meaningful only once a round has started.
    always_ff @(posedge clock) begin
        if (start) begin
            secret_q <= secret;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pos        <= '0;
            guess      <= '0;
            result     <= NEUTRAL;
            tries_left <= '0;
            busy       <= 1'b0;
            complete   <= 1'b0;
            failed     <= 1'b0;
        end else begin
            result <= NEUTRAL;
            if (start) begin
                state      <= LOAD;
                pos        <= '0;
                guess      <= '0;
                tries_left <= TW'(MAX_TRIES);
                busy       <= 1'b1;
                complete   <= 1'b0;
                failed     <= 1'b0;
            end else begin
                case (state)
                    LOAD: state <= MATCH;
                    MATCH: begin
                        if (at_end) begin
                            state    <= WIN;
                            busy     <= 1'b0;
                            complete <= 1'b1;
                        end else if (skip) begin
                            pos    <= pos + PW'(1);
                            result <= CORRECT;
                        end else if (hit) begin
                            pos    <= pos + PW'(1);
                            guess  <= (guess << 2) | SW'(cur_sym);
                            result <= CORRECT;
                        end else if (miss) begin
                            pos        <= '0;
                            guess      <= '0;
                            result     <= INCORRECT;
                            tries_left <= tries_left - TW'(1);
                            if (tries_left == TW'(1)) begin
                                state  <= LOSE;
                                busy   <= 1'b0;
                                failed <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_morse_matcher.sv
// Bench for morse_matcher (SYMBOLS=5, MAX_TRIES=3): directed game scenarios plus random rounds.
module tb_morse_matcher;
    import morse_pkg::*;

    localparam int SYM = 5;
    localparam int MT  = 3;
    localparam int TO  = 10;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_MATCH = 2;
    localparam int M_WIN   = 3;
    localparam int M_LOSE  = 4;

    logic           clock = 1'b0;
    logic           resetn;
    logic           start;
    logic [2*SYM-1:0] secret;
    logic           ld_dot;
    logic           ld_line;
    logic [2*SYM-1:0] guess;
    logic [1:0]     result;
    logic [1:0]     tries_left;
    logic           busy;
    logic           complete;
    logic           failed;

    always #5 clock = ~clock;

    morse_matcher #(
        .SYMBOLS        (SYM),
        .MAX_TRIES      (MT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .secret     (secret),
        .ld_dot     (ld_dot),
        .ld_line    (ld_line),
        .guess      (guess),
        .result     (result),
        .tries_left (tries_left),
        .busy       (busy),
        .complete   (complete),
        .failed     (failed)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Game-level reference: secret as symbol list, position, accepted symbols, tries.
    int               m_mode;
    int               m_pos;
    int               m_tries;
    int               m_idle;
    logic [2*SYM-1:0] m_sec;
    logic [2*SYM-1:0] m_guess;
    logic [1:0]       m_result;
    logic             m_busy;
    logic             m_complete;
    logic             m_failed;

    function automatic logic [1:0] sym_at(input int p);
        return m_sec[2*(SYM-1-p) +: 2];
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = 0; m_tries = 0; m_idle = 0;
        m_guess = '0; m_result = NEUTRAL;
        m_busy = 1'b0; m_complete = 1'b0; m_failed = 1'b0;
    endtask

    task automatic model_miss();
        m_result = INCORRECT;
        m_guess  = '0;
        m_pos    = 0;
        m_idle   = 0;
        m_tries  = m_tries - 1;
        if (m_tries == 0) begin
            m_mode = M_LOSE; m_busy = 1'b0; m_failed = 1'b1;
        end
    endtask

    task automatic model_edge(input logic st, input logic [2*SYM-1:0] sec,
                              input logic d, input logic l);
        logic [1:0] s;
        logic [1:0] p;
        m_result = NEUTRAL;
        if (st) begin
            m_mode = M_LOAD; m_sec = sec; m_pos = 0; m_guess = '0; m_tries = MT;
            m_idle = 0; m_busy = 1'b1; m_complete = 1'b0; m_failed = 1'b0;
        end else if (m_mode == M_LOAD) begin
            m_mode = M_MATCH;
        end else if (m_mode == M_MATCH) begin
            if (m_pos == SYM) begin
                m_mode = M_WIN; m_busy = 1'b0; m_complete = 1'b1;
            end else begin
                s = sym_at(m_pos);
                if (s == NONE || s == 2'b10) begin
                    m_pos++; m_result = CORRECT; m_idle = 0;
                end else if (d || l) begin
                    p = d ? DOT : LINE;
                    m_idle = 0;
                    if (p == s) begin
                        m_guess = {m_guess[2*SYM-3:0], p};
                        m_pos++;
                        m_result = CORRECT;
                    end else begin
                        model_miss();
                    end
                end else begin
`ifdef MORSE_TIMEOUT_EN
                    if (m_idle == TO - 1) model_miss();
                    else m_idle++;
`endif
                end
            end
        end
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s/%s: observed %0h expected %0h", tag, field, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "guess",      32'(guess),      32'(m_guess));
        chk(tag, "result",     32'(result),     32'(m_result));
        chk(tag, "tries_left", 32'(tries_left), 32'(m_tries));
        chk(tag, "busy",       32'(busy),       32'(m_busy));
        chk(tag, "complete",   32'(complete),   32'(m_complete));
        chk(tag, "failed",     32'(failed),     32'(m_failed));
    endtask

    task automatic step(input string tag, input logic st, input logic [2*SYM-1:0] sec,
                        input logic d, input logic l);
        start = st; secret = sec; ld_dot = d; ld_line = l;
        @(posedge clock);
        model_edge(st, sec, d, l);
        #1;
        start = 1'b0; ld_dot = 1'b0; ld_line = 1'b0;
        vectors++;
        check_all(tag);
    endtask

    localparam logic [2*SYM-1:0] SEC_A = 10'b0111010000;

    initial begin
        logic [1:0]       s;
        logic [2*SYM-1:0] rsec;
        int               rv;
        logic             d;
        logic             l;

        resetn = 1'b0; start = 1'b0; secret = '0; ld_dot = 1'b0; ld_line = 1'b0;
        model_reset();
        #12;
        vectors++;
        check_all("reset");
        resetn = 1'b1;

        // Win: dot, line, dot, then two empty slots are skipped.
        step("win_start", 1'b1, SEC_A, 1'b0, 1'b0);
        step("win_load",  1'b0, SEC_A, 1'b0, 1'b0);
        chk("win_load", "tries_left", 32'(tries_left), 32'd3);
        step("win_dot",   1'b0, SEC_A, 1'b1, 1'b0);
        chk("win_dot", "result", 32'(result), 32'(CORRECT));
        step("win_line",  1'b0, SEC_A, 1'b0, 1'b1);
        step("win_dot2",  1'b0, SEC_A, 1'b1, 1'b0);
        step("win_skip1", 1'b0, SEC_A, 1'b0, 1'b0);
        chk("win_skip1", "result", 32'(result), 32'(CORRECT));
        step("win_skip2", 1'b0, SEC_A, 1'b0, 1'b0);
        step("win_end",   1'b0, SEC_A, 1'b0, 1'b0);
        chk("win_end", "complete", 32'(complete), 32'd1);
        chk("win_end", "guess", 32'(guess), 32'(10'b0000011101));
        chk("win_end", "tries_left", 32'(tries_left), 32'd3);
        step("win_hold",  1'b0, SEC_A, 1'b1, 1'b0);

        // One mismatch, then a clean entry.
        step("mis_start", 1'b1, SEC_A, 1'b0, 1'b0);
        step("mis_load",  1'b0, SEC_A, 1'b0, 1'b0);
        step("mis_line",  1'b0, SEC_A, 1'b0, 1'b1);
        chk("mis_line", "result", 32'(result), 32'(INCORRECT));
        chk("mis_line", "tries_left", 32'(tries_left), 32'd2);
        step("mis_dot",   1'b0, SEC_A, 1'b1, 1'b0);
        step("mis_line2", 1'b0, SEC_A, 1'b0, 1'b1);
        step("mis_dot2",  1'b0, SEC_A, 1'b1, 1'b0);
        repeat (3) step("mis_tail", 1'b0, SEC_A, 1'b0, 1'b0);
        chk("mis_end", "complete", 32'(complete), 32'd1);

        // Lose: three wrong pulses, further pulses ignored.
        step("lose_start", 1'b1, SEC_A, 1'b0, 1'b0);
        step("lose_load",  1'b0, SEC_A, 1'b0, 1'b0);
        repeat (3) step("lose_wrong", 1'b0, SEC_A, 1'b0, 1'b1);
        chk("lose_end", "failed", 32'(failed), 32'd1);
        chk("lose_end", "busy", 32'(busy), 32'd0);
        chk("lose_end", "tries_left", 32'(tries_left), 32'd0);
        step("lose_ignore", 1'b0, SEC_A, 1'b1, 1'b0);
        chk("lose_ignore", "result", 32'(result), 32'(NEUTRAL));

        // Simultaneous pulses: dot takes precedence.
        step("sim_start", 1'b1, SEC_A, 1'b0, 1'b0);
        step("sim_load",  1'b0, SEC_A, 1'b0, 1'b0);
        step("sim_both",  1'b0, SEC_A, 1'b1, 1'b1);
        chk("sim_both", "result", 32'(result), 32'(CORRECT));

        // Asynchronous reset in the middle of a round.
        step("rst_start", 1'b1, SEC_A, 1'b0, 1'b0);
        step("rst_load",  1'b0, SEC_A, 1'b0, 1'b0);
        step("rst_dot",   1'b0, SEC_A, 1'b1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        vectors++;
        check_all("rst_async");
        @(posedge clock);
        #1;
        vectors++;
        check_all("rst_held");
        resetn = 1'b1;
        step("rst_after_dot",  1'b0, SEC_A, 1'b1, 1'b0);
        step("rst_after_line", 1'b0, SEC_A, 1'b0, 1'b1);
        chk("rst_after", "busy", 32'(busy), 32'd0);

`ifdef MORSE_TIMEOUT_EN
        step("to_start", 1'b1, SEC_A, 1'b0, 1'b0);
        step("to_load",  1'b0, SEC_A, 1'b0, 1'b0);
        repeat (TO - 1) step("to_wait", 1'b0, SEC_A, 1'b0, 1'b0);
        chk("to_wait", "tries_left", 32'(tries_left), 32'd3);
        step("to_expire", 1'b0, SEC_A, 1'b0, 1'b0);
        chk("to_expire", "result", 32'(result), 32'(INCORRECT));
        chk("to_expire", "tries_left", 32'(tries_left), 32'd2);
`endif

        // Random rounds, biased toward correct keying so some rounds are won.
        for (int r = 0; r < 25; r++) begin
            rsec = (2*SYM)'($urandom);
            step("rnd_start", 1'b1, rsec, 1'b0, 1'b0);
            for (int c = 0; c < 30; c++) begin
                if (m_mode == M_MATCH && m_pos < SYM) s = sym_at(m_pos);
                else s = DOT;
                rv = int'($urandom_range(0, 9));
                if (rv < 6) begin
                    d = (s != LINE); l = (s == LINE);
                end else if (rv < 8) begin
                    d = (s == LINE); l = !d;
                end else if (rv == 8) begin
                    d = 1'b1; l = 1'b1;
                end else begin
                    d = 1'b0; l = 1'b0;
                end
                step("rnd", 1'b0, rsec, d, l);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
